// File: rtl/prio_index_scanner_if.sv
// Handshake bundle for prio_index_scanner: mask-in stream and index-out stream.
// slave = scanner view, master = producer/consumer view.
interface prio_index_scanner_if #(
  parameter int WIDTH = 16
);
  localparam int IDX_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mask;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_empty;

  modport slave (
    input  in_valid, in_mask, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_empty
  );

  modport master (
    output in_valid, in_mask, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_empty
  );
endinterface

// File: rtl/prio_index_scanner.sv
// prio_index_scanner: accepts a WIDTH-bit mask and streams the index of every
// set bit, one per beat, in priority order (MSB_FIRST selects direction).
// An all-zero mask produces a single beat flagged empty.
// Optional macro PIS_FLUSH_EN adds a flush port that aborts a scan in progress.
module prio_index_scanner #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef PIS_FLUSH_EN
  input  logic                  flush,
`endif
  prio_index_scanner_if.slave   bus
);
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             empty_q, empty_d;
  logic [IDX_W-1:0] sel_idx;
  logic             one_hot;
  logic             last_w;
  logic             flush_w;
  logic             in_rdy;

`ifdef PIS_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Priority pick: the last match in scan order wins, so MSB-first scans upward
  // and LSB-first scans downward. A zero mask leaves the index at 0.
  always_comb begin
    sel_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++)
        if (mask_q[i]) sel_idx = IDX_W'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (mask_q[i]) sel_idx = IDX_W'(i);
    end
  end

  assign one_hot = (mask_q != '0) && ((mask_q & (mask_q - WIDTH'(1))) == '0);
  assign last_w  = empty_q | one_hot;
  assign in_rdy  = (state_q == IDLE) && !flush_w;

  // mask_q is zero whenever IDLE, so these need no extra gating by state.
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (state_q == SCAN);
  assign bus.out_idx   = sel_idx;
  assign bus.out_last  = last_w;
  assign bus.out_empty = empty_q;

  // Next state: accept in IDLE, retire one bit per transfer in SCAN, flush aborts.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    empty_d = empty_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_rdy) begin
          mask_d  = bus.in_mask;
          empty_d = (bus.in_mask == '0);
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (bus.out_ready) begin
          mask_d = mask_q & ~(WIDTH'(1) << sel_idx);
          if (last_w) begin
            state_d = IDLE;
            mask_d  = '0;
            empty_d = 1'b0;
          end
        end
        if (flush_w) begin
          state_d = IDLE;
          mask_d  = '0;
          empty_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = '0;
        empty_d = 1'b0;
      end
    endcase
  end

  // State and scan registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      empty_q <= empty_d;
    end
  end
endmodule

// File: tb/tb_prio_index_scanner.sv
// Directed bench for prio_index_scanner: an MSB-first and an LSB-first instance
// share all inputs; expected beats are hand-computed per vector.
module tb_prio_index_scanner;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_mask;
  logic        out_ready;
`ifdef PIS_FLUSH_EN
  logic        flush;
`endif
  int n_chk;
  int n_fail;

  prio_index_scanner_if #(.WIDTH(16)) b0 ();
  prio_index_scanner_if #(.WIDTH(16)) b1 ();

  assign b0.in_valid  = in_valid;
  assign b0.in_mask   = in_mask;
  assign b0.out_ready = out_ready;
  assign b1.in_valid  = in_valid;
  assign b1.in_mask   = in_mask;
  assign b1.out_ready = out_ready;

  prio_index_scanner #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef PIS_FLUSH_EN
    .flush (flush),
`endif
    .bus   (b0)
  );

  prio_index_scanner #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef PIS_FLUSH_EN
    .flush (flush),
`endif
    .bus   (b1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the next negedge with beat 1 showing.
  task automatic send(input logic [15:0] m);
    chk("accept_ready", 32'(b0.in_ready), 32'd1);
    in_valid = 1'b1;
    in_mask  = m;
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat1_valid", 32'(b0.out_valid), 32'd1);
  endtask

  // Check the displayed beat on one instance, then let it transfer.
  task automatic beat(input bit lsb, input int idx, input bit last, input bit empty);
    if (!lsb) begin
      chk("beat_valid", 32'(b0.out_valid), 32'd1);
      chk("beat_idx",   32'(b0.out_idx),   32'(idx));
      chk("beat_last",  32'(b0.out_last),  32'(last));
      chk("beat_empty", 32'(b0.out_empty), 32'(empty));
      chk("beat_busy",  32'(b0.in_ready),  32'd0);
    end else begin
      chk("lsb_valid",  32'(b1.out_valid), 32'd1);
      chk("lsb_idx",    32'(b1.out_idx),   32'(idx));
      chk("lsb_last",   32'(b1.out_last),  32'(last));
      chk("lsb_empty",  32'(b1.out_empty), 32'(empty));
    end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_ready"}, 32'(b0.in_ready),  32'd1);
    chk({tag, "_valid"}, 32'(b0.out_valid), 32'd0);
  endtask

  initial begin
    int e;
    int guard;
    bit r;
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_mask   = '0;
    out_ready = 1'b1;
`ifdef PIS_FLUSH_EN
    flush     = 1'b0;
`endif
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(b0.in_ready),  32'd1);
    chk("rst_valid", 32'(b0.out_valid), 32'd0);
    chk("rst_idx",   32'(b0.out_idx),   32'd0);
    chk("rst_last",  32'(b0.out_last),  32'd0);
    chk("rst_empty", 32'(b0.out_empty), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: two bits, MSB first
    send(16'h8001);
    beat(0, 15, 0, 0);
    beat(0, 0, 1, 0);
    idle_chk("t1_idle");

    // 2: empty mask
    send(16'h0000);
    beat(0, 0, 1, 1);
    idle_chk("t2_idle");

    // 3: LSB-first ordering
    send(16'h00A4);
    beat(1, 2, 0, 0);
    beat(1, 5, 0, 0);
    beat(1, 7, 1, 0);
    idle_chk("t3_idle");

    // 4: full mask with random stalls; in_valid held high with junk to prove it is ignored
    send(16'hFFFF);
    in_valid = 1'b1;
    in_mask  = 16'h1234;
    e = 15;
    guard = 0;
    while (e >= 0 && guard < 400) begin
      chk("t4_valid", 32'(b0.out_valid), 32'd1);
      chk("t4_idx",   32'(b0.out_idx),   32'(e));
      chk("t4_last",  32'(b0.out_last),  32'(e == 0));
      chk("t4_busy",  32'(b0.in_ready),  32'd0);
      r = 1'($urandom_range(0, 1));
      out_ready = r;
      @(negedge clk);
      if (r) e--;
      guard++;
    end
    in_valid = 1'b0;
    chk("t4_done", 32'(e), 32'hFFFF_FFFF);
    out_ready = 1'b1;
    idle_chk("t4_idle");
    @(negedge clk);
    idle_chk("t4_noacc");

    // 5: reset mid-scan
    send(16'hFFFF);
    beat(0, 15, 0, 0);
    beat(0, 14, 0, 0);
    beat(0, 13, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(b0.out_valid), 32'd0);
    chk("t5_rst_idx",   32'(b0.out_idx),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_chk("t5_idle");
    send(16'h0010);
    beat(0, 4, 1, 0);
    idle_chk("t5_end");

`ifdef PIS_FLUSH_EN
    // 6: flush mid-scan, then flush blocking accept in IDLE
    send(16'hF000);
    beat(0, 15, 0, 0);
    beat(0, 14, 0, 0);
    chk("t6_idx13", 32'(b0.out_idx), 32'd13);
    out_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("t6_fl_valid", 32'(b0.out_valid), 32'd0);
    chk("t6_fl_block", 32'(b0.in_ready),  32'd0);
    in_valid = 1'b1;
    in_mask  = 16'h0100;
    @(negedge clk);
    chk("t6_noacc", 32'(b0.out_valid), 32'd0);
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    idle_chk("t6_idle");
    send(16'h0003);
    beat(0, 1, 0, 0);
    beat(0, 0, 1, 0);
    idle_chk("t6_end");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
